// File: rtl/rr_nway_mux.sv
// rr_nway_mux: N-channel valid/ready mux, fixed select or round-robin, one output register.
// Optional out_par (registered ^out_data) when RR_NWAY_MUX_PARITY_EN is defined.
module rr_nway_mux #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
`ifdef RR_NWAY_MUX_PARITY_EN
    output logic                 out_par,
`endif
    input  logic                 out_ready
);

    logic [SELW-1:0]  rr_ptr;
    logic [SELW-1:0]  gnt_idx;
    logic             gnt_vld;
    logic [WIDTH-1:0] gnt_data;
    logic             can_load;
    logic             xfer;

    assign can_load = !out_valid || out_ready;
    assign xfer     = can_load && gnt_vld;

    // grant: fixed index, or lowest valid at/after rr_ptr, wrapping to lowest valid
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (mode) begin
            for (int k = NCH - 1; k >= 0; k--) begin
                if (in_valid[k]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SELW'(k);
                end
            end
            for (int k = NCH - 1; k >= 0; k--) begin
                if (in_valid[k] && SELW'(k) >= rr_ptr) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SELW'(k);
                end
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (in_valid[k] && sel == SELW'(k)) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SELW'(k);
                end
            end
        end
    end

    // data of the granted channel
    always_comb begin
        gnt_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (gnt_idx == SELW'(k)) begin
                gnt_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // one-hot ready to the granted channel; held low during reset
    always_comb begin
        in_ready = '0;
        for (int k = 0; k < NCH; k++) begin
            in_ready[k] = rstn && xfer && (gnt_idx == SELW'(k));
        end
    end

    // output register and round-robin pointer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
`ifdef RR_NWAY_MUX_PARITY_EN
            out_par   <= 1'b0;
`endif
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_ch    <= gnt_idx;
`ifdef RR_NWAY_MUX_PARITY_EN
            out_par   <= ^gnt_data;
`endif
            if (mode) begin
                rr_ptr <= (gnt_idx == SELW'(NCH - 1)) ? '0 : gnt_idx + SELW'(1);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_nway_mux.sv
// tb_rr_nway_mux: directed steps with a beat scoreboard.
// Two instances: NCH=4 main, NCH=3 for out-of-range select.
module tb_rr_nway_mux;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] d;
    } beat_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    logic [23:0] b_in_data;
    logic [2:0]  b_in_valid;
    logic [2:0]  b_in_ready;
    logic        b_mode;
    logic [1:0]  b_sel;
    logic [7:0]  b_out_data;
    logic [1:0]  b_out_ch;
    logic        b_out_valid;
    logic        b_out_ready;

`ifdef RR_NWAY_MUX_PARITY_EN
    logic        out_par;
    logic        b_out_par;
`endif

    int    vectors = 0;
    int    errs    = 0;
    beat_t sb[$];

    always #5 clk = ~clk;

    rr_nway_mux #(.WIDTH(8), .NCH(4), .SELW(2)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
`ifdef RR_NWAY_MUX_PARITY_EN
        .out_par   (out_par),
`endif
        .out_ready (out_ready)
    );

    rr_nway_mux #(.WIDTH(8), .NCH(3), .SELW(2)) dut3 (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .mode      (b_mode),
        .sel       (b_sel),
        .out_data  (b_out_data),
        .out_ch    (b_out_ch),
        .out_valid (b_out_valid),
`ifdef RR_NWAY_MUX_PARITY_EN
        .out_par   (b_out_par),
`endif
        .out_ready (b_out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] ch);
        beat_t b;
        b.ch = ch;
        b.d  = in_data[int'(ch)*8 +: 8];
        sb.push_back(b);
    endtask

    task automatic pop_check(input string tag);
        beat_t b;
        chk({tag, " sb_depth"}, sb.size(), 1);
        if (sb.size() > 0) begin
            b = sb.pop_front();
            chk({tag, " valid"}, out_valid, 1);
            chk({tag, " data"}, out_data, b.d);
            chk({tag, " ch"}, out_ch, b.ch);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] seq4 [3];
        logic [1:0] c;
        seq4 = '{2'd3, 2'd0, 2'd3};

        rstn        = 1'b0;
        mode        = 1'b0;
        sel         = 2'd2;
        in_valid    = 4'hF;
        in_data     = {8'hD3, 8'hA5, 8'h5A, 8'h0F};
        out_ready   = 1'b1;
        b_mode      = 1'b0;
        b_sel       = 2'd0;
        b_in_valid  = 3'b111;
        b_in_data   = {8'h99, 8'h88, 8'h66};
        b_out_ready = 1'b1;

        // reset state
        #12;
        chk("rst out_valid", out_valid, 0);
        chk("rst out_data", out_data, 8'h00);
        chk("rst out_ch", out_ch, 0);
        chk("rst in_ready", in_ready, 4'b0000);
        chk("rst b_in_ready", b_in_ready, 3'b000);
`ifdef RR_NWAY_MUX_PARITY_EN
        chk("rst out_par", out_par, 0);
`endif

        // fixed select after release
        rstn = 1'b1;
        #1;
        chk("fix in_ready", in_ready, 4'b0100);
        push(2'd2);
        tick();
        pop_check("fix beat");

        // NCH=3, sel=3 never grants; main instance drains
        b_sel    = 2'd3;
        in_valid = 4'h0;
        #1;
        chk("inv b_valid_pre", b_out_valid, 1);
        chk("inv b_ch_pre", b_out_ch, 0);
        chk("inv b_in_ready", b_in_ready, 3'b000);
        chk("drn in_ready", in_ready, 4'b0000);
        tick();
        chk("inv b_valid", b_out_valid, 0);
        chk("inv b_data_hold", b_out_data, 8'h66);
        chk("drn valid", out_valid, 0);
        chk("drn data_hold", out_data, 8'hA5);
        chk("drn ch_hold", out_ch, 2);

        // round-robin wrap 0,1,2,3,0
        mode     = 1'b1;
        in_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            c = 2'(i % 4);
            #1;
            chk("rr in_ready", in_ready, 4'b0001 << c);
            push(c);
            tick();
            pop_check("rr beat");
        end

        // round-robin skip from rr_ptr=1 over 4'b1001
        in_valid = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("skip in_ready", in_ready, 4'b0001 << seq4[i]);
            push(seq4[i]);
            tick();
            pop_check("skip beat");
        end

        // load 0x3C then stall three cycles with changing inputs
        mode           = 1'b0;
        sel            = 2'd1;
        in_data[15:8]  = 8'h3C;
        in_valid       = 4'b0010;
        #1;
        chk("bp load in_ready", in_ready, 4'b0010);
        push(2'd1);
        tick();
        pop_check("bp load");
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mode     = i[0];
            sel      = 2'(i);
            in_valid = 4'hF;
            in_data  = $urandom;
            #1;
            chk("stall in_ready", in_ready, 4'b0000);
            tick();
            chk("stall data", out_data, 8'h3C);
            chk("stall ch", out_ch, 1);
            chk("stall valid", out_valid, 1);
        end

        // release: same edge drains and loads ch1
        out_ready     = 1'b1;
        mode          = 1'b0;
        sel           = 2'd1;
        in_valid      = 4'b0010;
        in_data[15:8] = 8'h77;
        #1;
        chk("rel in_ready", in_ready, 4'b0010);
        push(2'd1);
        tick();
        pop_check("rel beat");
        in_valid = 4'h0;
        #1;
        chk("rel2 in_ready", in_ready, 4'b0000);
        tick();
        chk("rel2 valid", out_valid, 0);
        chk("rel2 data_hold", out_data, 8'h77);
        chk("rel2 ch_hold", out_ch, 1);

        // async reset during round-robin traffic
        mode     = 1'b1;
        in_valid = 4'hF;
        in_data  = {8'hD3, 8'hA5, 8'h5A, 8'h0F};
        for (int i = 0; i < 2; i++) begin
            c = 2'(i);
            #1;
            chk("pre in_ready", in_ready, 4'b0001 << c);
            push(c);
            tick();
            pop_check("pre beat");
        end
        #2;
        rstn = 1'b0;
        #1;
        chk("arst valid", out_valid, 0);
        chk("arst data", out_data, 8'h00);
        chk("arst ch", out_ch, 0);
        chk("arst in_ready", in_ready, 4'b0000);
        sb.delete();
        #1;
        rstn = 1'b1;
        #1;
        chk("post in_ready", in_ready, 4'b0001);
        push(2'd0);
        tick();
        pop_check("post beat");

`ifdef RR_NWAY_MUX_PARITY_EN
        mode         = 1'b0;
        sel          = 2'd0;
        in_valid     = 4'b0001;
        in_data[7:0] = 8'h07;
        tick();
        chk("par 07", out_par, 1);
        in_data[7:0] = 8'h03;
        tick();
        chk("par 03", out_par, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
